// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the pipeline and the iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dz;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo, dz
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo, dz
  );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) with fixed WIDTH+1 latency.
//   state | meaning
//   IDLE  | waiting for start; operands latched on accept
//   CALC  | one shift-add / shift-subtract iteration per cycle, WIDTH cycles
//   DONE  | results written on entry, done pulse for one cycle
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         resetn,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             div_r, neg_q, neg_r, bzero_r;
  logic [WIDTH-1:0] a_r, mcand, p_hi, p_lo;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             dz_q;

  logic             accept, last, is_signed;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] p_hi_nxt, p_lo_nxt;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             busy_c, done_c;

  assign is_signed = ~bus.op[0];
  assign a_mag     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign accept    = (state == IDLE) && bus.start && !bus.cancel;
  assign last      = (state == CALC) && (cnt == CW'(WIDTH - 1));

  // Multiply: conditional add then shift right; divide: restoring shift-left/subtract.
  assign sum     = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
  assign shifted = {p_hi, p_lo[WIDTH-1]};
  assign ge      = shifted >= {1'b0, mcand};
  assign diff    = shifted[WIDTH-1:0] - mcand;

  always_comb begin
    p_hi_nxt = sum[WIDTH:1];
    p_lo_nxt = {sum[0], p_lo[WIDTH-1:1]};
    if (div_r) begin
      p_hi_nxt = ge ? diff : shifted[WIDTH-1:0];
      p_lo_nxt = {p_lo[WIDTH-2:0], ge};
    end
  end

  // Sign fix-up is applied to the post-iteration values so results land on the DONE entry edge.
  assign prod     = {p_hi_nxt, p_lo_nxt};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -p_lo_nxt : p_lo_nxt;
  assign rem_fix  = neg_r ? -p_hi_nxt : p_hi_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.cancel) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nxt = CALC;
        CALC:    if (last) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      CALC: busy_c = 1'b1;
      DONE: begin
        busy_c = 1'b1;
        done_c = !bus.cancel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      div_r   <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      bzero_r <= 1'b0;
      a_r     <= '0;
      mcand   <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      div_r   <= bus.op[1];
      neg_q   <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      neg_r   <= is_signed & bus.a[WIDTH-1];
      bzero_r <= (bus.b == '0);
      a_r     <= bus.a;
      p_hi    <= '0;
      p_lo    <= bus.op[1] ? a_mag : b_mag;
      mcand   <= bus.op[1] ? b_mag : a_mag;
    end else if (state == CALC && !bus.cancel) begin
      cnt  <= cnt + CW'(1);
      p_hi <= p_hi_nxt;
      p_lo <= p_lo_nxt;
      if (last) begin
        if (!div_r) begin
          {hi_q, lo_q} <= prod_fix;
          dz_q         <= 1'b0;
        end else if (bzero_r) begin
          hi_q <= a_r;
          lo_q <= '1;
          dz_q <= 1'b1;
        end else begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
          dz_q <= 1'b0;
        end
      end
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.dz   = dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, cancel and reset behaviour at WIDTH=32.
module tb_muldiv_unit;
  localparam int W   = 32;
  localparam int LAT = W + 1;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  vec_t vecs [0:11];

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) n_done++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents an operation for one cycle, scrambles inputs afterwards, waits for done and checks it.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input string tag, input bit rel);
    int lat;
    @(negedge clk);
    if (rel) resetn = 1'b1;
    check_eq({tag, "_idle_busy"}, 64'(bus.busy), 64'(0));
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = ~o;
    bus.a     = $urandom;
    bus.b     = $urandom;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 2) check_eq({tag, "_calc_busy"}, 64'(bus.busy), 64'(1));
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(LAT));
    check_eq({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
    check_eq({tag, "_lo"}, 64'(bus.lo), 64'(elo));
    check_eq({tag, "_dz"}, 64'(bus.dz), 64'(edz));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nd;
    vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{2'b01, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
    vecs[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1};
    vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9]  = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{2'b11, 32'h12345678, 32'h000003E8, 32'h00000380, 32'h0004A90B, 1'b0};
    vecs[11] = '{2'b00, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0};

    resetn     = 1'b0;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = 2'b00;
    bus.a      = '0;
    bus.b      = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_hi", 64'(bus.hi), 64'(0));
    check_eq("rst_lo", 64'(bus.lo), 64'(0));
    check_eq("rst_dz", 64'(bus.dz), 64'(0));
    check_eq("rst_busy", 64'(bus.busy), 64'(0));
    check_eq("rst_done", 64'(bus.done), 64'(0));

    // Operations run back-to-back: each new start is in the cycle right after done.
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz,
             $sformatf("v%0d", i), i == 0);

    // start together with cancel must not launch anything
    @(negedge clk);
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.op     = 2'b11;
    bus.a      = 32'd100;
    bus.b      = 32'd7;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check_eq("startcancel_busy", 64'(bus.busy), 64'(0));

    // DIVU 100/7 cancelled in cycle 10
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    nd = n_done;
    repeat (9) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(negedge clk);
    check_eq("cancel_busy_before", 64'(bus.busy), 64'(1));
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    check_eq("cancel_busy_after", 64'(bus.busy), 64'(0));
    check_eq("cancel_done", 64'(bus.done), 64'(0));
    check_eq("cancel_hi", 64'(bus.hi), 64'(vecs[11].hi));
    check_eq("cancel_lo", 64'(bus.lo), 64'(vecs[11].lo));
    check_eq("cancel_no_pulse", 64'(n_done), 64'(nd));
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "after_cancel", 1'b0);

    // asynchronous reset in cycle 15 of a MULT
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'd5;
    bus.b     = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("areset_hi", 64'(bus.hi), 64'(0));
    check_eq("areset_lo", 64'(bus.lo), 64'(0));
    check_eq("areset_dz", 64'(bus.dz), 64'(0));
    check_eq("areset_busy", 64'(bus.busy), 64'(0));
    check_eq("areset_done", 64'(bus.done), 64'(0));
    nd = n_done;
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("areset_no_pulse", 64'(n_done), 64'(nd));
    check_eq("areset_idle_lo", 64'(bus.lo), 64'(0));

    run_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, "b2b_0", 1'b0);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "b2b_1", 1'b0);
    @(negedge clk);
    check_eq("final_done_low", 64'(bus.done), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; legal values are even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request an operation; sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2 bits: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: a is the multiplicand or dividend, b is the multiplier or divisor.
REQ-007 The block SHALL have port cancel, input, 1 bit: flush on exception or pipeline flush; aborts the current operation.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress (CALC or DONE); the pipeline stalls on it.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse signalling that hi, lo and dz are valid.
REQ-010 The block SHALL have ports hi and lo, output, WIDTH bits each: registered result.
REQ-011 The block SHALL have port dz, output, 1 bit: divide-by-zero flag of the last completed operation.

Function
REQ-012 The block SHALL implement three states: IDLE, CALC and DONE.
REQ-013 In IDLE, start=1 with cancel=0 SHALL latch op, a and b, take magnitudes for signed ops, zero the iteration counter and move to CALC.
REQ-014 CALC SHALL run exactly WIDTH radix-2 iterations, one per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-015 After the last iteration the block SHALL apply the sign fix-up and move to DONE, where it writes hi, lo and dz.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-017 Latency SHALL be fixed: start sampled at edge 0 gives done=1 in cycle WIDTH+1, for every op and operand value.
REQ-018 busy SHALL be 1 in CALC and DONE and 0 in IDLE; start is ignored while busy=1.
REQ-019 A new start SHALL be accepted in the cycle right after done; there are no dead cycles.
REQ-020 MULT SHALL produce {hi,lo} equal to the 2*WIDTH-bit two's-complement product of signed a and signed b.
REQ-021 MULTU SHALL produce {hi,lo} equal to the unsigned product.
REQ-022 DIV SHALL produce lo as the quotient truncated toward zero and hi as the remainder, taking the sign of the dividend.
REQ-023 DIV of the most negative value by -1 SHALL give lo equal to the most negative value and hi=0, with no flag.
REQ-024 DIVU SHALL produce lo as the unsigned quotient and hi as the unsigned remainder.
REQ-025 If b=0 for DIV or DIVU, the block SHALL still run the full latency and then give lo all ones, hi=a and dz=1.
REQ-026 dz SHALL be 0 for any completed multiply and for any divide with b nonzero.
REQ-027 Outputs hi, lo and dz SHALL hold their values between completions; they change only in DONE.
REQ-028 cancel=1 in any state SHALL force IDLE at the next edge, with done=0 in that cycle and hi, lo and dz unchanged.
REQ-029 If start and cancel are both 1 in the same IDLE cycle, cancel SHALL win and no operation starts.
REQ-030 Changes on a, b or op after the start cycle SHALL have no effect on the operation in progress.

Reset
REQ-031 resetn=0 SHALL immediately, asynchronously, force IDLE and set busy=0, done=0, hi=0, lo=0, dz=0 and the counter to 0.
REQ-032 Reset mid-operation SHALL discard the operation; no done pulse is produced after resetn rises.
REQ-033 The first start SHALL be accepted at the first rising edge with resetn=1.

Verification (WIDTH=32)
REQ-034 MULT with a=FFFFFFFD and b=00000005 -> done at cycle 33; hi=FFFFFFFF, lo=FFFFFFF1, dz=0.
REQ-035 MULTU with a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-036 DIV with a=FFFFFFF9 and b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV with a=80000000 and b=FFFFFFFF -> lo=80000000, hi=0.
REQ-037 DIVU with a=7 and b=0 -> done at cycle 33; lo=FFFFFFFF, hi=00000007, dz=1; a following MULTU 2*3 -> hi=0, lo=6, dz=0.
REQ-038 Start DIVU 100/7, then cancel at cycle 10 -> busy=0 at cycle 11; no done pulse; hi and lo keep their previous values; a new start is accepted at cycle 11.
REQ-039 resetn low at cycle 15 of a MULT -> all outputs 0 immediately; no done pulse; start and done back-to-back give two results with no idle gap.
